// File: rtl/sram_1rw_port_bridge.sv
// Write/read channel bridge onto a single-port 1RW SRAM macro: round-robin
// arbitration, registered macro pins and latency-tracked registered read return.
module sram_1rw_port_bridge #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_valid,
    output logic              rd_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_data_valid,
    output logic              csb0,
    output logic              web0,
    output logic [ADDR_W-1:0] addr0,
    output logic [DATA_W-1:0] din0,
    input  logic [DATA_W-1:0] dout0
);

    typedef enum logic {
        PRIO_WR = 1'b0,
        PRIO_RD = 1'b1
    } prio_t;

    prio_t              r_prio;
    logic               r_csb0;
    logic               r_web0;
    logic [ADDR_W-1:0]  r_addr0;
    logic [DATA_W-1:0]  r_din0;
    logic [DATA_W-1:0]  r_rd_data;
    logic               r_rd_data_valid;
    // Bit k is set k edges after a read accept; the top bit marks dout0 ready.
    logic [RD_LAT:0]    r_rd_pipe;

    logic               w_wr_grant;
    logic               w_rd_grant;
    logic               w_conflict;

    assign w_conflict = wr_valid && rd_valid;

    // Round-robin grant; priority only matters when both channels request.
    always_comb begin
        w_wr_grant = 1'b0;
        w_rd_grant = 1'b0;
        if (rst || !en) begin
            w_wr_grant = 1'b0;
            w_rd_grant = 1'b0;
        end else if (w_conflict) begin
            if (r_prio == PRIO_WR) begin
                w_wr_grant = 1'b1;
            end else begin
                w_rd_grant = 1'b1;
            end
        end else begin
            w_wr_grant = wr_valid;
            w_rd_grant = rd_valid;
        end
    end

    // Macro command register, priority pointer and read-return pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prio          <= PRIO_WR;
            r_csb0          <= 1'b1;
            r_web0          <= 1'b1;
            r_addr0         <= {ADDR_W{1'b0}};
            r_din0          <= {DATA_W{1'b0}};
            r_rd_data       <= {DATA_W{1'b0}};
            r_rd_data_valid <= 1'b0;
            r_rd_pipe       <= {(RD_LAT+1){1'b0}};
        end else begin
            if (w_wr_grant) begin
                r_csb0  <= 1'b0;
                r_web0  <= 1'b0;
                r_addr0 <= wr_addr;
                r_din0  <= wr_data;
            end else if (w_rd_grant) begin
                r_csb0  <= 1'b0;
                r_web0  <= 1'b1;
                r_addr0 <= rd_addr;
            end else begin
                r_csb0  <= 1'b1;
                r_web0  <= 1'b1;
            end

            // After a contested grant the losing channel goes first next time.
            if (w_conflict && w_wr_grant) begin
                r_prio <= PRIO_RD;
            end else if (w_conflict && w_rd_grant) begin
                r_prio <= PRIO_WR;
            end else begin
                r_prio <= r_prio;
            end

            r_rd_pipe <= {r_rd_pipe[RD_LAT-1:0], w_rd_grant};

            if (r_rd_pipe[RD_LAT]) begin
                r_rd_data       <= dout0;
                r_rd_data_valid <= 1'b1;
            end else begin
                r_rd_data_valid <= 1'b0;
            end
        end
    end

    assign wr_ready      = w_wr_grant;
    assign rd_ready      = w_rd_grant;
    assign csb0          = r_csb0;
    assign web0          = r_web0;
    assign addr0         = r_addr0;
    assign din0          = r_din0;
    assign rd_data       = r_rd_data;
    assign rd_data_valid = r_rd_data_valid;

endmodule

// File: tb/tb_sram_1rw_port_bridge.sv
// Directed bench for sram_1rw_port_bridge with a behavioural 1RW macro
// (registered dout0, one cycle read latency).
module tb_sram_1rw_port_bridge;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 16;
    localparam int RD_LAT = 1;

    logic              clk;
    logic              rst;
    logic              en;
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              rd_valid;
    logic              rd_ready;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_data_valid;
    logic              csb0;
    logic              web0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] din0;
    logic [DATA_W-1:0] dout0;

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    int checks   = 0;
    int failures = 0;

    sram_1rw_port_bridge #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .RD_LAT(RD_LAT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .rd_valid     (rd_valid),
        .rd_ready     (rd_ready),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .rd_data_valid(rd_data_valid),
        .csb0         (csb0),
        .web0         (web0),
        .addr0        (addr0),
        .din0         (din0),
        .dout0        (dout0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural macro: captures the registered command at the clock edge.
    always @(posedge clk) begin
        if (!csb0) begin
            if (!web0) mem[addr0] <= din0;
            else       dout0      <= mem[addr0];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        wr_valid = 1'b1; wr_addr = a; wr_data = d;
        #1;
        chk("wr_accept", wr_ready, 1'b1);
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic wait_rd(input string tag, input logic [DATA_W-1:0] exp);
        for (int i = 0; i < 8; i++) begin
            if (rd_data_valid === 1'b1) begin
                chk(tag, rd_data, exp);
                tick();
                return;
            end
            tick();
        end
        chk({tag, "_timeout"}, rd_data_valid, 1'b1);
    endtask

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 16'h0000;
        dout0 = 16'h0000;
        rst = 1'b1; en = 1'b0;
        wr_valid = 1'b0; wr_addr = 10'h000; wr_data = 16'h0000;
        rd_valid = 1'b0; rd_addr = 10'h000;

        // Reset state
        tick(); tick();
        en = 1'b1; wr_valid = 1'b1; rd_valid = 1'b1;
        #1;
        chk("rst_wr_ready", wr_ready, 1'b0);
        chk("rst_rd_ready", rd_ready, 1'b0);
        chk("rst_csb0", csb0, 1'b1);
        chk("rst_web0", web0, 1'b1);
        chk("rst_addr0", addr0, 10'h000);
        chk("rst_din0", din0, 16'h0000);
        chk("rst_rd_data", rd_data, 16'h0000);
        chk("rst_rd_valid", rd_data_valid, 1'b0);
        wr_valid = 1'b0; rd_valid = 1'b0;
        rst = 1'b0;

        // Write then read, exact latency
        wr_valid = 1'b1; wr_addr = 10'h005; wr_data = 16'hBEEF;
        #1;
        chk("t1_wr_ready", wr_ready, 1'b1);
        chk("t1_rd_ready_lo", rd_ready, 1'b0);
        tick();
        chk("t1_w_csb0", csb0, 1'b0);
        chk("t1_w_web0", web0, 1'b0);
        chk("t1_w_addr0", addr0, 10'h005);
        chk("t1_w_din0", din0, 16'hBEEF);
        wr_valid = 1'b0; rd_valid = 1'b1; rd_addr = 10'h005;
        #1;
        chk("t1_rd_ready", rd_ready, 1'b1);
        tick();
        rd_valid = 1'b0;
        chk("t1_r_csb0", csb0, 1'b0);
        chk("t1_r_web0", web0, 1'b1);
        chk("t1_r_din0_hold", din0, 16'hBEEF);
        chk("t1_valid_early1", rd_data_valid, 1'b0);
        tick();
        chk("t1_idle_csb0", csb0, 1'b1);
        chk("t1_valid_early2", rd_data_valid, 1'b0);
        tick();
        chk("t1_valid", rd_data_valid, 1'b1);
        chk("t1_data", rd_data, 16'hBEEF);
        tick();
        chk("t1_valid_once", rd_data_valid, 1'b0);
        chk("t1_data_hold", rd_data, 16'hBEEF);

        // Conflict round-robin: W,R,W,R then back to W
        rst = 1'b1; tick(); rst = 1'b0;
        wr_valid = 1'b1; wr_addr = 10'h010; wr_data = 16'h1111;
        rd_valid = 1'b1; rd_addr = 10'h005;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk("t2_wr_ready", wr_ready, (c % 2 == 0) ? 1'b1 : 1'b0);
            chk("t2_rd_ready", rd_ready, (c % 2 == 1) ? 1'b1 : 1'b0);
            chk("t2_exclusive", wr_ready & rd_ready, 1'b0);
            tick();
        end
        #1;
        chk("t2_prio_back_wr", wr_ready, 1'b1);
        wr_valid = 1'b0; rd_valid = 1'b0;
        tick(); tick(); tick(); tick();

        // Streaming reads after preload
        for (int i = 0; i < 8; i++) do_write(10'(i), 16'h1000 + 16'(i));
        tick(); tick(); tick();
        for (int c = 0; c < 14; c++) begin
            if (c < 8) begin
                rd_valid = 1'b1; rd_addr = 10'(c);
            end else begin
                rd_valid = 1'b0;
            end
            #1;
            if (c < 8) chk("t3_rd_ready", rd_ready, 1'b1);
            chk("t3_strobe", rd_data_valid, (c >= 3 && c < 11) ? 1'b1 : 1'b0);
            if (c >= 3 && c < 11) chk("t3_data", rd_data, 16'h1000 + 16'(c - 3));
            tick();
        end

        // Same-cycle hazard at prio=READ
        rst = 1'b1; tick(); rst = 1'b0;
        do_write(10'h3FF, 16'h0001);
        wr_valid = 1'b1; wr_addr = 10'h3FF; wr_data = 16'h0001;
        rd_valid = 1'b1; rd_addr = 10'h000;
        #1;
        chk("t4_setup_w", wr_ready, 1'b1);
        tick();
        wr_data = 16'h00AA; rd_addr = 10'h3FF;
        #1;
        chk("t4_prio_rd", rd_ready, 1'b1);
        chk("t4_prio_rd_wlo", wr_ready, 1'b0);
        tick();
        rd_valid = 1'b0;
        #1;
        chk("t4_w_after", wr_ready, 1'b1);
        tick();
        wr_valid = 1'b0; rd_valid = 1'b1; rd_addr = 10'h3FF;
        #1;
        chk("t4_rd2_ready", rd_ready, 1'b1);
        tick();
        rd_valid = 1'b0;
        wait_rd("t4_old_data", 16'h0001);
        wait_rd("t4_new_data", 16'h00AA);

        // Same-cycle hazard at prio=WRITE
        do_write(10'h3FF, 16'h0001);
        wr_valid = 1'b1; wr_addr = 10'h3FF; wr_data = 16'h00AA;
        rd_valid = 1'b1; rd_addr = 10'h3FF;
        #1;
        chk("t4b_w_first", wr_ready, 1'b1);
        tick();
        wr_valid = 1'b0;
        #1;
        chk("t4b_rd_next", rd_ready, 1'b1);
        tick();
        rd_valid = 1'b0;
        wait_rd("t4b_new_data", 16'h00AA);
        tick(); tick();

        // en gating with a read in flight
        rd_valid = 1'b1; rd_addr = 10'h010;
        #1;
        chk("t5_rd_ready", rd_ready, 1'b1);
        tick();
        en = 1'b0; wr_valid = 1'b1; wr_addr = 10'h020; wr_data = 16'h5A5A;
        for (int c = 1; c <= 3; c++) begin
            #1;
            chk("t5_wr_ready_gated", wr_ready, 1'b0);
            chk("t5_rd_ready_gated", rd_ready, 1'b0);
            if (c >= 2) chk("t5_csb0_idle", csb0, 1'b1);
            chk("t5_strobe", rd_data_valid, (c == 3) ? 1'b1 : 1'b0);
            if (c == 3) chk("t5_data", rd_data, 16'h1111);
            tick();
        end
        en = 1'b1; wr_valid = 1'b0; rd_valid = 1'b0;
        tick(); tick();

        // Reset mid-read
        rd_valid = 1'b1; rd_addr = 10'h010;
        #1;
        chk("t6_rd_ready", rd_ready, 1'b1);
        tick();
        rd_valid = 1'b0; rst = 1'b1;
        tick();
        chk("t6_csb0", csb0, 1'b1);
        chk("t6_rd_data", rd_data, 16'h0000);
        chk("t6_valid", rd_data_valid, 1'b0);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk("t6_no_strobe", rd_data_valid, 1'b0);
            tick();
        end
        rd_valid = 1'b1; rd_addr = 10'h010;
        #1;
        chk("t6_first_grant", rd_ready, 1'b1);
        tick();
        rd_valid = 1'b0;
        wait_rd("t6_after_rst_data", 16'h1111);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
